// File: rtl/cpu_types_pkg.sv
// Shared datapath types for the MIPS pipeline: register/word widths, the MEM-stage
// writeback select, FSM state and the EX/MEM latch layout.
package cpu_types_pkg;

  localparam int unsigned WordW = 32;
  localparam int unsigned RegW  = 5;

  typedef logic [WordW-1:0] word_t;
  typedef logic [RegW-1:0]  regbits_t;

  typedef enum logic [1:0] {
    MtrAlu  = 2'b00,
    MtrLoad = 2'b01,
    MtrPc4  = 2'b10,
    MtrLui  = 2'b11
  } memtoreg_t;

  typedef enum logic {
    StIdle,
    StAccess
  } mem_state_t;

  typedef struct packed {
    logic      valid;
    logic      d_ren;
    logic      d_wen;
    word_t     aluout;
    word_t     rdat2;
    word_t     pc4;
    word_t     lui_imm;
    word_t     instr;
    regbits_t  wsel;
    logic      reg_wr;
    logic      halt;
    memtoreg_t mem_to_reg;
  } ex_mem_t;

  function automatic logic is_word_aligned(input word_t addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/mem_wdat_mux.sv
// Writeback data select for the MEM stage: ALU result, load data, PC+4 or LUI immediate.
module mem_wdat_mux
  import cpu_types_pkg::*;
(
  input  memtoreg_t sel_i,
  input  word_t     alu_i,
  input  word_t     load_i,
  input  word_t     pc4_i,
  input  word_t     lui_i,
  output word_t     wdat_o
);

  always_comb begin
    wdat_o = alu_i;
    unique case (sel_i)
      MtrAlu:  wdat_o = alu_i;
      MtrLoad: wdat_o = load_i;
      MtrPc4:  wdat_o = pc4_i;
      MtrLui:  wdat_o = lui_i;
      default: wdat_o = alu_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: EX/MEM latch, dcache request FSM, writeback select, sticky halt,
// misalign detection and a saturating dcache stall counter.
module mem_stage
  import cpu_types_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ex_valid,
  input  logic             ex_dREN,
  input  logic             ex_dWEN,
  input  word_t            ex_aluout,
  input  word_t            ex_rdat2,
  input  word_t            ex_pc4,
  input  word_t            ex_lui_imm,
  input  word_t            ex_instr,
  input  regbits_t         ex_wsel,
  input  logic             ex_RegWr,
  input  logic             ex_halt,
  input  logic [1:0]       ex_MemToReg,
  input  logic             flush,
  input  logic             dhit,
  input  word_t            dmemload,
  output logic             dmemREN,
  output logic             dmemWEN,
  output word_t            dmemaddr,
  output word_t            dmemstore,
  output logic             mem_busy,
  output logic             wb_valid,
  output logic             wb_RegWr,
  output logic             wb_halt,
  output logic             wb_dREN,
  output regbits_t         wb_wsel,
  output word_t            wb_wdat,
  output word_t            wb_instr,
  output logic             misalign,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  ex_mem_t          ex_mem_q, ex_mem_d;
  mem_state_t       state_q, state_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             mem_op, in_access;
  word_t            wdat;

  assign mem_op    = ex_mem_q.valid & (ex_mem_q.d_ren | ex_mem_q.d_wen);
  assign in_access = (state_q == StAccess);
  assign mem_busy  = in_access & ~dhit;
  assign misalign  = mem_op & ~is_word_aligned(ex_mem_q.aluout);

  // Load wins if both enables were latched.
  assign dmemREN   = in_access & ex_mem_q.d_ren;
  assign dmemWEN   = in_access & ex_mem_q.d_wen & ~ex_mem_q.d_ren;
  assign dmemaddr  = in_access ? ex_mem_q.aluout : '0;
  assign dmemstore = in_access ? ex_mem_q.rdat2 : '0;

  always_comb begin
    ex_mem_d    = ex_mem_q;
    state_d     = state_q;
    halted_d    = halted_q;
    stall_cnt_d = stall_cnt_q;
    if (!mem_busy) begin
      if (flush || halted_q) begin
        ex_mem_d = '0;
      end else begin
        ex_mem_d.valid      = ex_valid;
        ex_mem_d.d_ren      = ex_dREN;
        ex_mem_d.d_wen      = ex_dWEN;
        ex_mem_d.aluout     = ex_aluout;
        ex_mem_d.rdat2      = ex_rdat2;
        ex_mem_d.pc4        = ex_pc4;
        ex_mem_d.lui_imm    = ex_lui_imm;
        ex_mem_d.instr      = ex_instr;
        ex_mem_d.wsel       = ex_wsel;
        ex_mem_d.reg_wr     = ex_RegWr;
        ex_mem_d.halt       = ex_halt;
        ex_mem_d.mem_to_reg = memtoreg_t'(ex_MemToReg);
      end
      // The access starts on the same edge that captures the instruction.
      state_d = (ex_mem_d.valid && (ex_mem_d.d_ren || ex_mem_d.d_wen) &&
                 is_word_aligned(ex_mem_d.aluout)) ? StAccess : StIdle;
    end
    if (wb_valid && ex_mem_q.halt) begin
      halted_d = 1'b1;
    end
    if (mem_busy && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ex_mem_q    <= '0;
      state_q     <= StIdle;
      halted_q    <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      ex_mem_q    <= ex_mem_d;
      state_q     <= state_d;
      halted_q    <= halted_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  mem_wdat_mux u_wdat_mux (
    .sel_i  (ex_mem_q.mem_to_reg),
    .alu_i  (ex_mem_q.aluout),
    .load_i (dmemload),
    .pc4_i  (ex_mem_q.pc4),
    .lui_i  (ex_mem_q.lui_imm),
    .wdat_o (wdat)
  );

  assign wb_valid  = ex_mem_q.valid & ~mem_busy;
  assign wb_RegWr  = wb_valid & ex_mem_q.reg_wr & ~misalign;
  assign wb_halt   = wb_valid & ex_mem_q.halt;
  assign wb_dREN   = wb_valid & ex_mem_q.d_ren;
  assign wb_wsel   = wb_valid ? ex_mem_q.wsel : '0;
  assign wb_wdat   = wb_valid ? wdat : '0;
  assign wb_instr  = wb_valid ? ex_mem_q.instr : '0;
  assign halted    = halted_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline MEM stage of the 5-stage MIPS datapath: holds the EX/MEM latch and drives the dcache request.
- Selects the writeback data and presents it to the MEM/WB latch, plus the stall that freezes the upstream stages while a data access is outstanding.
- Also owns sticky halt, misaligned-access detection and a saturating dcache stall-cycle counter.

Parameters:
- CNT_W, 16, width of the stall-cycle performance counter.

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- ex_valid  in  1  EX presents a real instruction (0 = bubble)
- ex_dREN, ex_dWEN  in  1 each  load / store request
- ex_aluout  in  word_t  ALU result / effective address
- ex_rdat2  in  word_t  store data
- ex_pc4, ex_lui_imm, ex_instr  in  word_t each  passthrough values
- ex_wsel  in  regbits_t  destination register
- ex_RegWr, ex_halt  in  1 each
- ex_MemToReg  in  2  00 alu, 01 load, 10 pc4, 11 lui
- flush  in  1  squash the capture into the EX/MEM latch
- dhit  in  1  dcache access complete
- dmemload  in  word_t  load data
- dmemREN, dmemWEN  out  1 each
- dmemaddr, dmemstore  out  word_t each
- mem_busy  out  1  stall to PC/IF/ID/EX and the MEM/WB enable (active low)
- wb_valid, wb_RegWr, wb_halt, wb_dREN  out  1 each  to MEM/WB
- wb_wsel  out  regbits_t
- wb_wdat, wb_instr  out  word_t each
- misalign  out  1  pulse, the latched access was not word aligned
- halted  out  1  sticky halt
- stall_cnt  out  CNT_W  dcache stall cycles, saturating

Behaviour:
- Reset (nRST=0, asynchronous):
  - The latch becomes a bubble: all fields 0.
  - FSM goes to IDLE; halted, stall_cnt, misalign and all dmem* are 0.
  - mem_busy=0 and every wb_* output is 0.
- Latch capture: on the CLK rising edge when mem_busy=0.
  - flush=1 or halted=1 loads a bubble; otherwise it loads the ex_* values.
  - When mem_busy=1 the latch holds and ex_*/flush are ignored. A flush never cancels an in-flight access; EX must hold flush until mem_busy=0.
- FSM states: IDLE, ACCESS.
  - IDLE→ACCESS: latched valid & (dREN|dWEN) & aluout[1:0]==0, entered on the capture edge.
  - ACCESS→IDLE: on dhit.
  - ACCESS: dmemREN=dREN, dmemWEN=dWEN, dmemaddr=aluout, dmemstore=rdat2; held stable until dhit.
  - dmemREN and dmemWEN are never both 1; if both are latched, the load wins.
- mem_busy = (state==ACCESS) & ~dhit, combinational. A zero-wait dhit gives a single-cycle MEM stage.
- Latency:
  - Non-memory instruction: 1 cycle EX→wb outputs.
  - Memory instruction: 1 + N cycles, N = cycles until dhit (N≥1).
- Load data is taken combinationally from dmemload in the dhit cycle; there is no extra register.
- wb_wdat is muxed by MemToReg: 00 aluout, 01 dmemload, 10 pc4, 11 lui_imm.
- Forwarded wb_* outputs:
  - wb_valid = latched valid & ~mem_busy; all other wb_* are 0 when wb_valid=0.
  - wb_RegWr = RegWr & ~misalign.
- Misalign: latched valid & (dREN|dWEN) & aluout[1:0]!=0.
  - No dcache request is made and no stall occurs.
  - misalign is 1 for that latch cycle; the instruction retires with RegWr suppressed.
- Halt: halted is set at the edge where a valid latched instruction with halt=1 retires (wb_valid=1). It is sticky until reset; all later captures become bubbles.
- stall_cnt: +1 every cycle mem_busy=1; saturates at all-ones and does not wrap.
- Reset mid-access drops the request immediately; the dcache is reset by the same nRST.

Decomposition:
- cpu_types_pkg: word_t, regbits_t, and a new memtoreg_t enum (ALU, LOAD, PC4, LUI).
- Also in cpu_types_pkg: a mem_state_t enum and an ex_mem_t packed struct for the latch.
- One sub-module, mem_wdat_mux: combinational 4:1 writeback select.

Test Plan:
- ALU op: ex_valid=1, MemToReg=00, aluout=0x0000_0010, wsel=5, RegWr=1 → next cycle wb_valid=1, wb_wdat=0x10, wb_wsel=5, no dmemREN, mem_busy=0.
- Load with 3-cycle dhit: aluout=0x100, dmemload=0xDEADBEEF → dmemREN=1 and dmemaddr=0x100 for 3 cycles, mem_busy=1 for 2 cycles, wb_wdat=0xDEADBEEF in the dhit cycle, stall_cnt=2.
- Store: dWEN=1, aluout=0x200, rdat2=0x1234 → dmemWEN=1, dmemstore=0x1234 until dhit; a flush asserted mid-stall is ignored, and the store still completes.
- Misaligned load: aluout=0x102 → misalign=1 for one cycle, no dmemREN, wb_RegWr=0, mem_busy=0.
- Halt: latched halt=1 → halted=1 after retire; subsequent ex_valid=1 inputs give wb_valid=0; reset clears halted.
- Counter saturation with CNT_W=4: hold dhit=0 for 20 cycles → stall_cnt stays at 15; nRST low mid-access → dmemREN=0 and stall_cnt=0 immediately, without a clock edge.
